// File: rtl/y_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   state_e      : divider FSM states
//   cnt_width()  : step-counter width for a given operand width
//   Div0Quotient : quotient returned on divide-by-zero (all ones)
package y_div_pkg;

  localparam int unsigned DivWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  // One spare bit so the counter can hold WIDTH itself without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned StepCntW = cnt_width(DivWidth);

  localparam logic [DivWidth-1:0] Div0Quotient = '1;

endpackage

// File: rtl/y_div_seq_if.sv
// Request/response bundle between the EX stage and the divider.
//   master : drives start, is_signed, dividend, divisor; observes results
//   slave  : the divider side
interface y_div_seq_if
  import y_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/y_div_step.sv
// One combinational restoring-division step.
//   rem_i      : partial remainder before the step (always < dvs_i)
//   dvd_msb_i  : next dividend bit shifted into the remainder
//   dvs_i      : divisor magnitude
//   next_rem_o : partial remainder after the step
//   q_bit_o    : quotient bit produced by this step
module y_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] next_rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // The shifted remainder keeps its carry-out bit: with a divisor above 2^(WIDTH-1) the
  // remainder can have its MSB set, and dropping it would corrupt the trial subtract.
  always_comb begin
    shifted    = {rem_i, dvd_msb_i};
    trial      = {1'b0, shifted} - {2'b00, dvs_i};
    q_bit_o    = ~trial[WIDTH+1];
    // Either result is below the divisor, so the low WIDTH bits carry it exactly.
    next_rem_o = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/y_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU, one trial subtract per clock.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, aborts any division in flight
//   div_io : start/is_signed/dividend/divisor in; busy/done/quotient/remainder/div_zero out
// Latency is WIDTH+2 edges from the accepting edge to the edge that raises done.
module y_div_seq
  import y_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic         clk,
  input  logic         reset,
  y_div_seq_if.slave   div_io
);

  localparam int unsigned       CntW     = cnt_width(WIDTH);
  localparam logic [CntW-1:0]   LastStep = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] orig_dvd_q, orig_dvd_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] next_rem;
  logic             q_bit;

  y_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i      (rem_q),
    .dvd_msb_i  (dvd_q[WIDTH-1]),
    .dvs_i      (dvs_q),
    .next_rem_o (next_rem),
    .q_bit_o    (q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    orig_dvd_d  = orig_dvd_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (div_io.start) begin
          state_d    = StRun;
          cnt_d      = '0;
          rem_d      = '0;
          dvd_d      = (div_io.is_signed && div_io.dividend[WIDTH-1]) ?
                       -div_io.dividend : div_io.dividend;
          dvs_d      = (div_io.is_signed && div_io.divisor[WIDTH-1]) ?
                       -div_io.divisor : div_io.divisor;
          orig_dvd_d = div_io.dividend;
          neg_quot_d = div_io.is_signed & (div_io.dividend[WIDTH-1] ^ div_io.divisor[WIDTH-1]);
          neg_rem_d  = div_io.is_signed & div_io.dividend[WIDTH-1];
          dz_d       = (div_io.divisor == '0);
        end
      end
      StRun: begin
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        rem_d = next_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (dz_q) begin
          // Fixed divide-by-zero result; no sign correction.
          quotient_d  = '1;
          remainder_d = orig_dvd_q;
        end else begin
          // most-negative / -1 wraps back to most-negative here with no special case.
          quotient_d  = neg_quot_q ? -dvd_q : dvd_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      orig_dvd_q  <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      orig_dvd_q  <= orig_dvd_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  assign div_io.busy      = (state_q != StIdle);
  assign div_io.done      = done_q;
  assign div_io.quotient  = quotient_q;
  assign div_io.remainder = remainder_q;
  assign div_io.div_zero  = div_zero_q;

endmodule

// File: tb/tb_y_div_seq.sv
// Self-checking bench for y_div_seq: expected results are queued when an operation is
// issued and popped when the divider raises done.
module tb_y_div_seq;

  localparam int unsigned W       = 32;
  localparam int          Latency = W + 2;
  localparam int          MaxWait = 100;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  y_div_seq_if #(.WIDTH(W)) bus ();

  y_div_seq #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .div_io (bus)
  );

  always #5 clk = ~clk;

  // Reference: host 64-bit arithmetic, truncating division (remainder follows dividend).
  function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, lq, lr;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      lq = sa / sb_;
      lr = sa % sb_;
      e.q = lq[W-1:0]; e.r = lr[W-1:0]; e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive one request for a single accepting edge; returns #1 after that edge.
  task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges (first = edges already elapsed, accept edge included) until done is seen.
  task automatic wait_done(input int first, output int edges, output bit ok);
    edges = first;
    ok    = 1'b0;
    while (edges < MaxWait) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d edges, required done", edges);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b1;   // reset must win over start
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd5;
    bus.divisor   = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    if (bus.quotient !== '0) begin
      n_fail++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient);
    end
    if (bus.remainder !== '0) begin
      n_fail++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder);
    end
    if (bus.div_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero);
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    exp_t e; int edges; bit ok;
    issue(1'b0, 32'd100, 32'd7, '{q: 32'd14, r: 32'd2, dz: 1'b0});
    wait_done(1, edges, ok);
    e = sb.pop_front();
    if (ok) begin
      n_checks += 4;
      if (edges != Latency) begin
        n_fail++; $display("FAIL unsigned_latency: got %0d expected %0d", edges, Latency);
      end
      if (bus.quotient !== e.q) begin
        n_fail++; $display("FAIL unsigned_quotient: got %h expected %h", bus.quotient, e.q);
      end
      if (bus.remainder !== e.r) begin
        n_fail++; $display("FAIL unsigned_remainder: got %h expected %h", bus.remainder, e.r);
      end
      if (bus.div_zero !== e.dz) begin
        n_fail++; $display("FAIL unsigned_div_zero: got %b expected %b", bus.div_zero, e.dz);
      end
    end
  endtask

  task automatic test_signed();
    exp_t e; int edges; bit ok;
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic [W-1:0] q [2];
    logic [W-1:0] r [2];
    a[0] = 32'hFFFF_FF9C; b[0] = 32'd7;        q[0] = 32'hFFFF_FFF2; r[0] = 32'hFFFF_FFFE;
    a[1] = 32'd100;       b[1] = 32'hFFFF_FFF9; q[1] = 32'hFFFF_FFF2; r[1] = 32'd2;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, a[i], b[i], '{q: q[i], r: r[i], dz: 1'b0});
      wait_done(1, edges, ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks += 3;
        if (bus.quotient !== e.q) begin
          n_fail++; $display("FAIL signed%0d_quotient: got %h expected %h", i, bus.quotient, e.q);
        end
        if (bus.remainder !== e.r) begin
          n_fail++;
          $display("FAIL signed%0d_remainder: got %h expected %h", i, bus.remainder, e.r);
        end
        if (bus.div_zero !== e.dz) begin
          n_fail++; $display("FAIL signed%0d_div_zero: got %b expected 0", i, bus.div_zero);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e; int edges; bit ok;
    issue(1'b0, 32'h1234_5678, 32'd0, '{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1});
    wait_done(1, edges, ok);
    e = sb.pop_front();
    if (ok) begin
      n_checks += 4;
      if (edges != Latency) begin
        n_fail++; $display("FAIL div0_latency: got %0d expected %0d", edges, Latency);
      end
      if (bus.quotient !== e.q) begin
        n_fail++; $display("FAIL div0_quotient: got %h expected %h", bus.quotient, e.q);
      end
      if (bus.remainder !== e.r) begin
        n_fail++; $display("FAIL div0_remainder: got %h expected %h", bus.remainder, e.r);
      end
      if (bus.div_zero !== 1'b1) begin
        n_fail++; $display("FAIL div0_flag: got %b expected 1", bus.div_zero);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e; int edges; bit ok;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0});
      else        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, '{q: 32'd0, r: 32'h8000_0000, dz: 1'b0});
      wait_done(1, edges, ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks += 3;
        if (bus.quotient !== e.q) begin
          n_fail++; $display("FAIL ovf%0d_quotient: got %h expected %h", i, bus.quotient, e.q);
        end
        if (bus.remainder !== e.r) begin
          n_fail++; $display("FAIL ovf%0d_remainder: got %h expected %h", i, bus.remainder, e.r);
        end
        if (bus.div_zero !== 1'b0) begin
          n_fail++; $display("FAIL ovf%0d_div_zero: got %b expected 0", i, bus.div_zero);
        end
      end
    end
  endtask

  // start stays high for the whole operation and is dropped in the done cycle.
  task automatic test_start_held();
    exp_t e; int pulses;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd5;
    sb.push_back('{q: 32'd15, r: 32'd2, dz: 1'b0});
    for (int c = 0; c < 2 * Latency + 4; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++; $display("FAIL held_busy: got %b expected 1", bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        pulses++;
        bus.start = 1'b0;
        if (pulses == 1) begin
          e = sb.pop_front();
          n_checks += 2;
          if (bus.quotient !== e.q) begin
            n_fail++; $display("FAIL held_quotient: got %h expected %h", bus.quotient, e.q);
          end
          if (bus.remainder !== e.r) begin
            n_fail++; $display("FAIL held_remainder: got %h expected %h", bus.remainder, e.r);
          end
        end
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL held_done_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb; int edges; bit ok;
    issue(1'b0, 32'd50, 32'd5, '{q: 32'd10, r: 32'd0, dz: 1'b0});
    wait_done(1, edges, ok);
    ea = sb.pop_front();
    if (!ok) return;
    n_checks++;
    if (bus.quotient !== ea.q) begin
      n_fail++; $display("FAIL b2b_first_quotient: got %h expected %h", bus.quotient, ea.q);
    end
    // Still inside the done cycle: the next request must be accepted.
    issue(1'b0, 32'd1000, 32'd3, '{q: 32'd333, r: 32'd1, dz: 1'b0});
    repeat (W) begin
      @(posedge clk);
      #1;
    end
    // W+1 edges in: last cycle before the second done, first results must still hold.
    n_checks += 4;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_early_done: got %b expected 0", bus.done);
    end
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy: got %b expected 1", bus.busy);
    end
    if (bus.quotient !== ea.q) begin
      n_fail++; $display("FAIL b2b_hold_quotient: got %h expected %h", bus.quotient, ea.q);
    end
    if (bus.remainder !== ea.r) begin
      n_fail++; $display("FAIL b2b_hold_remainder: got %h expected %h", bus.remainder, ea.r);
    end
    wait_done(W + 1, edges, ok);
    eb = sb.pop_front();
    if (ok) begin
      n_checks += 3;
      if (edges != Latency) begin
        n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", edges, Latency);
      end
      if (bus.quotient !== eb.q) begin
        n_fail++; $display("FAIL b2b_second_quotient: got %h expected %h", bus.quotient, eb.q);
      end
      if (bus.remainder !== eb.r) begin
        n_fail++; $display("FAIL b2b_second_remainder: got %h expected %h", bus.remainder, eb.r);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int edges; bit ok;
    issue(1'b0, 32'h0000_FFFF, 32'd3, model(1'b0, 32'h0000_FFFF, 32'd3));
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());   // aborted, never completes
    n_checks += 5;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: got %b expected 0", bus.done);
    end
    if (bus.quotient !== '0) begin
      n_fail++; $display("FAIL abort_quotient: got %h expected 0", bus.quotient);
    end
    if (bus.remainder !== '0) begin
      n_fail++; $display("FAIL abort_remainder: got %h expected 0", bus.remainder);
    end
    if (bus.div_zero !== 1'b0) begin
      n_fail++; $display("FAIL abort_div_zero: got %b expected 0", bus.div_zero);
    end
    issue(1'b0, 32'd9, 32'd3, '{q: 32'd3, r: 32'd0, dz: 1'b0});
    wait_done(1, edges, ok);
    e = sb.pop_front();
    if (ok) begin
      n_checks += 2;
      if (bus.quotient !== e.q) begin
        n_fail++; $display("FAIL after_abort_quotient: got %h expected %h", bus.quotient, e.q);
      end
      if (bus.remainder !== e.r) begin
        n_fail++; $display("FAIL after_abort_remainder: got %h expected %h", bus.remainder, e.r);
      end
    end
  endtask

  task automatic test_random();
    exp_t e; int edges; bit ok;
    bit s; logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom_range(1, 300);
        1:       b = -$urandom_range(1, 300);
        2:       b = 32'h8000_0000 | $urandom;
        3:       b = '0;
        default: b = $urandom;
      endcase
      issue(s, a, b, model(s, a, b));
      wait_done(1, edges, ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks += 3;
        if (bus.quotient !== e.q) begin
          n_fail++;
          $display("FAIL rand%0d_quotient (s=%b %h/%h): got %h expected %h",
                   i, s, a, b, bus.quotient, e.q);
        end
        if (bus.remainder !== e.r) begin
          n_fail++;
          $display("FAIL rand%0d_remainder (s=%b %h/%h): got %h expected %h",
                   i, s, a, b, bus.remainder, e.r);
        end
        if (bus.div_zero !== e.dz) begin
          n_fail++;
          $display("FAIL rand%0d_div_zero: got %b expected %b", i, bus.div_zero, e.dz);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
